// File: rtl/control_unit_pkg.sv
// Shared types for the control unit: T-state encoding, opcode values, instruction classes.
// Also holds the small per-class sequencing helpers used by the top.
package control_unit_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    C_REG_ALU, C_IMM_ALU, C_UNARY, C_LDI, C_LD, C_ST, C_MULDIV, C_BR,
    C_JR, C_JAL, C_MFHI, C_MFLO, C_IN, C_OUT, C_NOP, C_HALT
  } iclass_t;

  // Final T-state of each class; the boundary decision (Stop) is taken there.
  function automatic state_t last_state(input iclass_t c);
    case (c)
      C_REG_ALU, C_IMM_ALU, C_LDI:            return S_T5;
      C_UNARY, C_JAL:                         return S_T4;
      C_LD, C_ST:                             return S_T7;
      C_MULDIV, C_BR:                         return S_T6;
      C_JR, C_MFHI, C_MFLO, C_IN, C_OUT:      return S_T3;
      default:                                return S_T2;
    endcase
  endfunction

  function automatic logic is_mem_state(input state_t s, input iclass_t c);
    return (s == S_T1) || (s == S_T6 && c == C_LD) || (s == S_T7 && c == C_ST);
  endfunction

  function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
    case (op)
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_instr_decode.sv
// Combinational IR[31:27] -> instruction class; unused codes fall through to nop.
// mul/div classify as muldiv only when CONTROL_UNIT_MULDIV_EN is defined.
module instr_decode
  import control_unit_pkg::*;
(
  input  logic [4:0] op,
  output iclass_t    iclass
);

  always_comb begin
    iclass = C_NOP;
    case (op)
      OP_LD:   iclass = C_LD;
      OP_LDI:  iclass = C_LDI;
      OP_ST:   iclass = C_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
               iclass = C_REG_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:
               iclass = C_IMM_ALU;
`ifdef CONTROL_UNIT_MULDIV_EN
      OP_DIV, OP_MUL: iclass = C_MULDIV;
`else
      OP_DIV, OP_MUL: iclass = C_NOP;
`endif
      OP_NEG, OP_NOT: iclass = C_UNARY;
      OP_BR:   iclass = C_BR;
      OP_JR:   iclass = C_JR;
      OP_JAL:  iclass = C_JAL;
      OP_IN:   iclass = C_IN;
      OP_OUT:  iclass = C_OUT;
      OP_MFHI: iclass = C_MFHI;
      OP_MFLO: iclass = C_MFLO;
      OP_NOP:  iclass = C_NOP;
      OP_HALT: iclass = C_HALT;
      default: iclass = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch T0-T2 (3 cycles + MEM_WAIT), execute up to T7; strobes decode state+IR.
// Stop halts at the instruction boundary; CONTROL_UNIT_MULDIV_EN enables the mul/div sequence.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Read,
  output logic        Write,
  output logic        IncPC,
  output logic [4:0]  opcode,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        HIin,
  output logic        LOin,
  output logic        Yin,
  output logic        Zin,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Outportin,
  output logic        CONin,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        PCout,
  output logic        MDRout,
  output logic        Inportout,
  output logic        Cout,
  output logic        Run
);

  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  state_t        state, state_nxt;
  iclass_t       iclass;
  logic [4:0]    op;
  logic [CW-1:0] wait_cnt;
  logic          mem_now, mem_next, wait_done;
  logic          unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];

  instr_decode u_decode (
    .op     (op),
    .iclass (iclass)
  );

  assign mem_now   = is_mem_state(state, iclass);
  assign mem_next  = is_mem_state(state_nxt, iclass);
  assign wait_done = (wait_cnt == '0);

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Memory states reload the down-counter on entry and hold until it drains.
      if (mem_now && !wait_done)
        wait_cnt <= wait_cnt - CW'(1);
      else if (!mem_now && mem_next)
        wait_cnt <= CW'(MEM_WAIT);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_T0;
      S_HALT: state_nxt = S_HALT;
      default: begin
        if (mem_now && !wait_done)
          state_nxt = state;
        else if (state == S_T2 && iclass == C_HALT)
          state_nxt = S_HALT;
        else if (state == last_state(iclass))
          state_nxt = Stop ? S_HALT : S_T0;
        else
          state_nxt = state_t'(state + 4'd1);
      end
    endcase
  end

  always_comb begin
    Read = 1'b0; Write = 1'b0; IncPC = 1'b0; opcode = 5'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; Yin = 1'b0; Zin = 1'b0; PCin = 1'b0; IRin = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; Outportin = 1'b0; CONin = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    PCout = 1'b0; MDRout = 1'b0; Inportout = 1'b0; Cout = 1'b0;
    Run = (state != S_HALT);
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (iclass)
          C_REG_ALU, C_IMM_ALU: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_UNARY: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
          C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
`ifdef CONTROL_UNIT_MULDIV_EN
          C_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
`endif
          C_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          C_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          C_JAL:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          C_MFHI: begin Gra = 1'b1; Rin = 1'b1; HIout = 1'b1; end
          C_MFLO: begin Gra = 1'b1; Rin = 1'b1; LOout = 1'b1; end
          C_IN:   begin Gra = 1'b1; Rin = 1'b1; Inportout = 1'b1; end
          C_OUT:  begin Gra = 1'b1; Rout = 1'b1; Outportin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (iclass)
          C_REG_ALU: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
          C_IMM_ALU: begin Cout = 1'b1; Zin = 1'b1; opcode = imm_alu_op(op); end
          C_UNARY:   begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD; end
`ifdef CONTROL_UNIT_MULDIV_EN
          C_MULDIV:  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
`endif
          C_BR:      begin PCout = 1'b1; Yin = 1'b1; end
          C_JAL:     begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (iclass)
          C_REG_ALU, C_IMM_ALU, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
`ifdef CONTROL_UNIT_MULDIV_EN
          C_MULDIV:   begin Zlowout = 1'b1; LOin = 1'b1; end
`endif
          C_BR:       begin Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD; end
          default: ;
        endcase
      end
      S_T6: begin
        case (iclass)
          C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
`ifdef CONTROL_UNIT_MULDIV_EN
          C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
`endif
          C_BR:     begin Zlowout = 1'b1; PCin = CON_FF; end
          default: ;
        endcase
      end
      S_T7: begin
        case (iclass)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
